// File: rtl/cpu_defs.sv
// Shared core constants: reset level, zero values, stop/write encodings, stall-vector indices,
// and the MEM/WB boundary control encoding.
package cpu_defs;
    localparam logic        RstEnable_n  = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [1:0] {
        WB_LOAD   = 2'd0,
        WB_BUBBLE = 2'd1,
        WB_HOLD   = 2'd2
    } wb_ctl_e;
endpackage

// File: rtl/wb_lane_reg.sv
// One writeback lane register: valid/wreg/wd/wdata with load, bubble and hold controls.
// Latency 1 cycle; bubble beats load, and with neither asserted the lane holds its value.
module wb_lane_reg
    import cpu_defs::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic              i_wreg,
    input  logic [ADDR_W-1:0] i_wd,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_valid,
    output logic              o_wreg,
    output logic [ADDR_W-1:0] o_wd,
    output logic [DATA_W-1:0] o_wdata
);
    logic              r_valid;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_valid <= 1'b0;
            r_wreg  <= WriteDisable;
            r_wd    <= '0;
            r_wdata <= '0;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_wreg  <= WriteDisable;
            r_wd    <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_wreg  <= i_wreg;
            r_wd    <= i_wd;
            r_wdata <= i_wdata;
        end
    end

    assign o_valid = r_valid;
    assign o_wreg  = r_wreg;
    assign o_wd    = r_wd;
    assign o_wdata = r_wdata;
endmodule

// File: rtl/mem_wb_multi.sv
// MEM/WB boundary for NUM_LANES writeback lanes plus HI/LO; 1-cycle latency.
// Priority: flush bubble > stall[STAGE]&!stall[STAGE+1] bubble > both stalled hold > load.
// Perf counters live only when MEM_WB_PERF_EN is defined; otherwise the ports are tied to 0.
module mem_wb_multi
    import cpu_defs::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE     = 4,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall,
    input  logic                        flush,
    input  logic [NUM_LANES-1:0]        mem_valid,
    input  logic [NUM_LANES-1:0]        mem_wreg,
    input  logic [NUM_LANES*ADDR_W-1:0] mem_wd,
    input  logic [NUM_LANES*DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0]           mem_hi,
    input  logic [DATA_W-1:0]           mem_lo,
    input  logic                        mem_whilo,
    output logic [NUM_LANES-1:0]        wb_valid,
    output logic [NUM_LANES-1:0]        wb_wreg,
    output logic [NUM_LANES*ADDR_W-1:0] wb_wd,
    output logic [NUM_LANES*DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0]           wb_hi,
    output logic [DATA_W-1:0]           wb_lo,
    output logic                        wb_whilo,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
);
    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("mem_wb_multi: STAGE+1 must be below STALL_W");
        end
    endgenerate

    // Lane 0 is oldest: a lane keeps its write only if no younger lane targets the same register.
    function automatic logic [NUM_LANES-1:0] collision_mask(
        input logic [NUM_LANES-1:0]        we,
        input logic [NUM_LANES*ADDR_W-1:0] wd
    );
        logic [NUM_LANES-1:0] keep;
        keep = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            keep[i] = we[i] && (wd[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (we[j] && (wd[j*ADDR_W +: ADDR_W] == wd[i*ADDR_W +: ADDR_W]))
                    keep[i] = 1'b0;
            end
        end
        return keep;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    wb_ctl_e              w_ctl;
    logic                 w_load;
    logic                 w_bubble;
    logic [NUM_LANES-1:0] w_wreg_keep;
    logic                 w_unused_stall;

    always_comb begin
        w_ctl = WB_LOAD;
        if (flush)
            w_ctl = WB_BUBBLE;
        else if (stall[STAGE] == Stop)
            w_ctl = (stall[STAGE+1] == Stop) ? WB_HOLD : WB_BUBBLE;
    end

    assign w_load         = (w_ctl == WB_LOAD);
    assign w_bubble       = (w_ctl == WB_BUBBLE);
    assign w_wreg_keep    = collision_mask(mem_wreg & mem_valid, mem_wd);
    assign w_unused_stall = ^stall;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            wb_lane_reg #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_load),
                .i_bubble (w_bubble),
                .i_valid  (mem_valid[g]),
                .i_wreg   (w_wreg_keep[g]),
                .i_wd     (mem_wd[g*ADDR_W +: ADDR_W]),
                .i_wdata  (mem_wdata[g*DATA_W +: DATA_W]),
                .o_valid  (wb_valid[g]),
                .o_wreg   (wb_wreg[g]),
                .o_wd     (wb_wd[g*ADDR_W +: ADDR_W]),
                .o_wdata  (wb_wdata[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_whilo;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= WriteDisable;
        end else if (w_bubble) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= WriteDisable;
        end else if (w_load) begin
            r_hi    <= mem_hi;
            r_lo    <= mem_lo;
            r_whilo <= mem_whilo & (|mem_valid);
        end
    end

    assign wb_hi    = r_hi;
    assign wb_lo    = r_lo;
    assign wb_whilo = r_whilo;

`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable_n) begin
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_load)   r_retire_cnt <= r_retire_cnt + popcount(mem_valid);
            if (w_bubble) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign retire_cnt = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed-vector scoreboard bench for mem_wb_multi (NUM_LANES=2, STAGE=4, STALL_W=6).
module tb_mem_wb_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [1:0]  mem_valid = '0, mem_wreg = '0;
    logic [9:0]  mem_wd = '0;
    logic [63:0] mem_wdata = '0;
    logic [31:0] mem_hi = '0, mem_lo = '0;
    logic        mem_whilo = 1'b0;
    logic [1:0]  wb_valid, wb_wreg;
    logic [9:0]  wb_wd;
    logic [63:0] wb_wdata;
    logic [31:0] wb_hi, wb_lo, retire_cnt, bubble_cnt;
    logic        wb_whilo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  v, w;
        logic [9:0]  wd;
        logic [63:0] wdata;
        logic [31:0] hi, lo;
        logic        wh;
        logic [31:0] r, b;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    mem_wb_multi dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.name, ".valid"}, 64'(wb_valid), 64'(e.v));
        chk({e.name, ".wreg"},  64'(wb_wreg),  64'(e.w));
        chk({e.name, ".wd"},    64'(wb_wd),    64'(e.wd));
        chk({e.name, ".wdata"}, wb_wdata,      e.wdata);
        chk({e.name, ".hi"},    64'(wb_hi),    64'(e.hi));
        chk({e.name, ".lo"},    64'(wb_lo),    64'(e.lo));
        chk({e.name, ".whilo"}, 64'(wb_whilo), 64'(e.wh));
        chk({e.name, ".retire"}, 64'(retire_cnt), 64'(e.r));
        chk({e.name, ".bubble"}, 64'(bubble_cnt), 64'(e.b));
    endtask

    function automatic exp_t mk(input string nm, input logic [1:0] v, w,
                                input logic [4:0] a1, a0, input logic [31:0] d1, d0, h, l,
                                input logic wh, input int r, b);
        exp_t e;
        e.name = nm; e.v = v; e.w = w; e.wd = {a1, a0}; e.wdata = {d1, d0};
        e.hi = h; e.lo = l; e.wh = wh;
`ifdef MEM_WB_PERF_EN
        e.r = 32'(r); e.b = 32'(b);
`else
        e.r = 32'(r) & 32'h0; e.b = 32'(b) & 32'h0;
`endif
        return e;
    endfunction

    // Drive one bundle (caller is at a negedge), queue its expected result, advance one cycle.
    task automatic vec(input logic [5:0] st, input logic fl, input logic [1:0] v, w,
                       input logic [4:0] a1, a0, input logic [31:0] d1, d0, h, l,
                       input logic wh, input exp_t e);
        stall = st; flush = fl; mem_valid = v; mem_wreg = w;
        mem_wd = {a1, a0}; mem_wdata = {d1, d0}; mem_hi = h; mem_lo = l; mem_whilo = wh;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: registered outputs present a new result after every edge that has a queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end

    exp_t zero_e, held;

    initial begin
        zero_e = mk("reset", 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        #2;
        chk_all(zero_e);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        vec(6'b000000, 0, 2'b01, 2'b01, 5'd0, 5'd3, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0,
            mk("load", 2'b01, 2'b01, 5'd0, 5'd3, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1, 0));
        vec(6'b010000, 0, 2'b11, 2'b11, 5'd5, 5'd6, 32'h1, 32'h2, 32'hAA, 32'hBB, 1'b1,
            mk("bubble", 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
        held = mk("preload", 2'b01, 2'b01, 5'd2, 5'd7, 32'h55, 32'h1234, 32'h100, 32'h200, 1'b1, 2, 1);
        vec(6'b000000, 0, 2'b01, 2'b11, 5'd2, 5'd7, 32'h55, 32'h1234, 32'h100, 32'h200, 1'b1, held);
        for (int k = 0; k < 3; k++) begin
            held.name = $sformatf("hold%0d", k);
            vec(6'b110000, 0, 2'b11, 2'b11, 5'd8 + 5'(k), 5'd9, 32'hF0 + k, 32'hE0, 32'h3, 32'h4, 1'b1, held);
        end
        vec(6'b000000, 0, 2'b11, 2'b11, 5'd9, 5'd9, 32'h22, 32'h11, 32'h0, 32'h0, 1'b1,
            mk("collide", 2'b11, 2'b10, 5'd9, 5'd9, 32'h22, 32'h11, 32'h0, 32'h0, 1'b1, 4, 1));
        vec(6'b000000, 0, 2'b11, 2'b11, 5'd4, 5'd0, 32'h44, 32'h33, 32'h0, 32'h0, 1'b0,
            mk("addr0", 2'b11, 2'b10, 5'd4, 5'd0, 32'h44, 32'h33, 32'h0, 32'h0, 1'b0, 6, 1));
        vec(6'b110000, 1, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1,
            mk("flush", 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6, 2));
        vec(6'b000000, 0, 2'b00, 2'b11, 5'd2, 5'd1, 32'h6, 32'h5, 32'h7, 32'h8, 1'b1,
            mk("novalid", 2'b00, 2'b00, 5'd2, 5'd1, 32'h6, 32'h5, 32'h7, 32'h8, 1'b0, 6, 2));
        vec(6'b000000, 0, 2'b10, 2'b10, 5'd31, 5'd1, 32'hFFFFFFFF, 32'h9, 32'h0, 32'h0, 1'b0,
            mk("lane1", 2'b10, 2'b10, 5'd31, 5'd1, 32'hFFFFFFFF, 32'h9, 32'h0, 32'h0, 1'b0, 7, 2));

        // Async reset asserted mid-cycle while a hold is requested.
        stall = 6'b110000;
        rst = 1'b0;
        #1;
        zero_e.name = "async_rst";
        chk_all(zero_e);
        @(negedge clk);
        rst = 1'b1;
        vec(6'b110000, 0, 2'b11, 2'b11, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1,
            mk("post_rst_hold", 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0));
        vec(6'b000000, 0, 2'b11, 2'b11, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1,
            mk("post_rst_load", 2'b11, 2'b10, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 2, 0));

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised MEM/WB pipeline boundary register for a multi-issue core. Carries NUM_LANES register-write channels plus one HI/LO channel from MEM to WB.
- Stall-vector control with correct hold semantics, an explicit flush, and same-bundle write-collision resolution.
- Optional retire/bubble performance counters.
- Sits between the memory-access stage and the regfile/HI-LO write ports.

Parameters:
- NUM_LANES, 2, number of parallel writeback lanes (1..4)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STALL_W, 6, width of the pipeline stall vector
- STAGE, 4, stall-vector index of this boundary's upstream stage; STAGE+1 < STALL_W is required, otherwise elaboration error
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (rst==0 resets)
- stall  in  STALL_W  per-stage stop vector, 1 = stop
- flush  in  1  squash MEM contents (exception/eret)
- mem_valid  in  NUM_LANES  lane carries a real instruction
- mem_wreg  in  NUM_LANES  lane register-write enable
- mem_wd  in  NUM_LANES*ADDR_W  lane destination, lane i at [i*ADDR_W +: ADDR_W]
- mem_wdata  in  NUM_LANES*DATA_W  lane write data, same packing
- mem_hi, mem_lo  in  DATA_W each  HI/LO values
- mem_whilo  in  1  HI/LO write enable
- wb_valid, wb_wreg  out  NUM_LANES
- wb_wd  out  NUM_LANES*ADDR_W
- wb_wdata  out  NUM_LANES*DATA_W
- wb_hi, wb_lo  out  DATA_W
- wb_whilo  out  1
- retire_cnt  out  CNT_W  instructions retired into WB
- bubble_cnt  out  CNT_W  bubble cycles inserted

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately): all wb_* outputs are 0 (wb_wd = NOP address 0, write enables disabled), counters 0.
- One-cycle latency. Per rising edge, evaluated in strict priority order:
  1. flush=1 -> bubble: valid/wreg/whilo = 0, wd/wdata/hi/lo = 0. flush wins over any stall pattern.
  2. stall[STAGE]=1 and stall[STAGE+1]=0 -> bubble (same zero values as flush).
  3. stall[STAGE]=1 and stall[STAGE+1]=1 -> hold: all wb_* retain their values. The previous generation loaded here; the successor must hold.
  4. stall[STAGE]=0 -> load from mem_*.
- Lane gating on load: wb_wreg[i] = mem_wreg[i] & mem_valid[i]. wb_wd and wb_wdata are captured unconditionally.
- Collision rule on load: lanes are ordered oldest = lane 0, youngest = lane NUM_LANES-1. If two or more lanes would write the same nonzero address, only the youngest keeps wb_wreg=1; older duplicates are cleared.
  - Writes to address 0 are always cleared, i.e. wb_wreg[i] = 0 when wd==0.
- HI/LO on load: wb_whilo = mem_whilo & (|mem_valid). wb_hi/wb_lo are captured unconditionally.
- Counters (see Optional Feature), both wrap modulo 2^CNT_W:
  - retire_cnt += popcount(mem_valid) on load cycles only.
  - bubble_cnt += 1 on each bubble cycle, whether from flush or stall.
- Reset asserted mid-stall or mid-flush overrides everything. The first edge after release follows the normal priority rules.

Optional Feature:
- Macro MEM_WB_PERF_EN.
- Defined: retire_cnt and bubble_cnt are live registers as described above.
- Undefined: both ports remain for interface stability but are driven constant 0, and no counter flops are synthesized.

Decomposition:
- Shared defines/package cpu_defs holds:
  - RstEnable_n (0), ZeroWord, NOPRegAddr
  - Stop / NoStop, WriteEnable / WriteDisable
  - stall-index constants (STALL_IF..STALL_WB)
- One sub-module, wb_lane_reg: single-lane valid/wreg/wd/wdata register with load/bubble/hold controls. It is instantiated NUM_LANES times via generate.
- Collision masking and popcount are combinational functions in the top module.

Test Plan:
- Reset/load: rst low, then high; stall=0, lane0 {valid=1, wreg=1, wd=3, wdata=0xDEADBEEF} -> next edge wb_wd[0]=3, wb_wdata[0]=0xDEADBEEF, wb_wreg[0]=1, retire_cnt=1.
- Bubble: stall=6'b010000 (STAGE=4) with valid inputs -> wb_wreg=0, wb_wd=0, wb_whilo=0, bubble_cnt increments by 1.
- Hold: load wd=7/0x1234, then stall=6'b110000 for 3 cycles while inputs change -> outputs stay 7/0x1234 for all 3 cycles, counters unchanged.
- Collision: lane0 and lane1 both wd=9 with wreg=1 (data 0x11, 0x22) -> wb_wreg=2'b10, wb_wdata[1]=0x22. Separately, lane0 wd=0 -> wb_wreg[0]=0.
- Flush priority: flush=1 with stall=6'b110000 -> bubble, not hold. Async reset pulse mid-cycle -> outputs zero immediately, before the next clk edge.
- Macro off: rebuild without MEM_WB_PERF_EN and run the load test -> retire_cnt and bubble_cnt read 0 throughout.
